// File: rtl/demux1to4_buf.sv
// demux1to4_buf: routes one W-bit valid/ready stream to one of four output
// lanes chosen per beat by s_sel. Each lane has a 2-entry buffer, so a stalled
// consumer only blocks the input while a beat for its own lane is presented.
// m_valid / m_data come straight from registers.
// The optional DEMUX_CNT_EN macro adds four 8-bit pop counters exported on m_cnt.
// rst_n is asserted asynchronously; its release is synchronized internally, and
// s_ready stays low until that synchronized release has happened.

// One output lane: a 2-entry FIFO made of a head register and a tail register.
module demux1to4_lane #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [1:0]   occ_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;

    // Next-state logic. Push is never raised at occ 2, and pop never at occ 0.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = data_i;
                    occ_d  = 2'd1;
                end else begin
                    tail_d = data_i;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            2'b11: head_d = data_i;  // only possible at occ 1: the new beat replaces the head
            default: ;
        endcase
    end

    // Buffer registers. Reset clears occupancy and contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o   = occ_q;
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = head_q;
endmodule

module demux1to4_buf #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [1:0]   s_sel,
    input  logic [W-1:0] s_data,
    output logic [3:0]   m_valid,
    input  logic [3:0]   m_ready,
    output logic [W-1:0] m_data0,
    output logic [W-1:0] m_data1,
    output logic [W-1:0] m_data2,
    output logic [W-1:0] m_data3
`ifdef DEMUX_CNT_EN
    ,
    output logic [31:0]  m_cnt
`endif
);
    // The lane buffer is built as an explicit head/tail pair, so only DEPTH = 2 exists.
    if (DEPTH != 2) begin : g_bad_depth
        $error("demux1to4_buf: DEPTH must be 2");
    end

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [3:0]          push, pop, full;
    logic [3:0][1:0]     occ;
    logic [3:0][W-1:0]   head;

    // Reset synchronizer: assertion takes effect immediately, release follows two clk edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // s_ready looks only at the selected lane's occupancy; m_ready has no path to it.
    assign s_ready = rst_int_n & ~full[s_sel];
    assign pop     = m_valid & m_ready;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign full[gi] = (occ[gi] == 2'd2);
        assign push[gi] = s_valid & s_ready & (s_sel == 2'(gi));

        demux1to4_lane #(.W(W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_int_n),
            .push_i  (push[gi]),
            .pop_i   (pop[gi]),
            .data_i  (s_data),
            .occ_o   (occ[gi]),
            .valid_o (m_valid[gi]),
            .data_o  (head[gi])
        );
    end

    assign m_data0 = head[0];
    assign m_data1 = head[1];
    assign m_data2 = head[2];
    assign m_data3 = head[3];

`ifdef DEMUX_CNT_EN
    logic [3:0][7:0] cnt_q, cnt_d;

    // Per-lane delivered-beat counters; they wrap from 8'hFF back to 8'h00.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) cnt_d[i] = cnt_q[i] + 8'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign m_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux1to4_buf.sv
// Self-checking bench for demux1to4_buf. A per-lane scoreboard queue is filled
// when the bench's own model decides that a beat is accepted. The queue is then
// compared against m_valid / m_data on every cycle. A vector table covers basic
// routing and the fill/stall case. Short hand-written sequences cover
// head-of-line blocking, push+pop at occ 1, and async reset.
module tb_demux1to4_buf;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [1:0]   s_sel;
    logic [W-1:0] s_data;
    logic [3:0]   m_valid;
    logic [3:0]   m_ready;
    logic [W-1:0] m_data0, m_data1, m_data2, m_data3;
`ifdef DEMUX_CNT_EN
    logic [31:0]  m_cnt;
`endif

    demux1to4_buf #(.W(W), .DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sel   (s_sel),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data0 (m_data0),
        .m_data1 (m_data1),
        .m_data2 (m_data2),
        .m_data3 (m_data3)
`ifdef DEMUX_CNT_EN
        ,
        .m_cnt   (m_cnt)
`endif
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic         live;          // model: synchronized reset has been released
    logic [W-1:0] sb [4][$];     // expected contents of each lane, head first

    typedef struct {
        logic         v;
        logic [1:0]   sel;
        logic [W-1:0] d;
        logic [3:0]   mr;
        logic         chk;   // compare s_ready against rdy
        logic         rdy;
    } vec_t;
    vec_t tbl [12];

    function automatic vec_t mk(logic v, logic [1:0] sel, logic [W-1:0] d,
                                logic [3:0] mr, logic chk, logic rdy);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.mr = mr; r.chk = chk; r.rdy = rdy;
        return r;
    endfunction

    function automatic logic [W-1:0] mdata(int i);
        case (i)
            0:       return m_data0;
            1:       return m_data1;
            2:       return m_data2;
            default: return m_data3;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(logic v, logic [1:0] sel, logic [W-1:0] d, logic [3:0] mr);
        s_valid = v;
        s_sel   = sel;
        s_data  = d;
        m_ready = mr;
    endtask

    // One clock: compare outputs at the falling edge, then update the model at the rising edge.
    task automatic cyc();
        logic         acc;
        logic [3:0]   pops;
        logic [1:0]   sel;
        logic [W-1:0] d;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m_valid[%0d]", i), 32'(m_valid[i]), 32'(sb[i].size() != 0));
            if (sb[i].size() != 0)
                chk($sformatf("m_data%0d", i), 32'(mdata(i)), 32'(sb[i][0]));
            pops[i] = (sb[i].size() != 0) && m_ready[i];
        end
        sel = s_sel;
        d   = s_data;
        acc = s_valid && live && (sb[sel].size() != 2);
        if (s_valid) chk("s_ready", 32'(s_ready), 32'(acc));
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (pops[i]) void'(sb[i].pop_front());
        if (acc) sb[sel].push_back(d);
        #1;
    endtask

    initial begin
        // basic route, consumers always ready
        tbl[0]  = mk(1'b1, 2'd0, 2'b01, 4'b1111, 1'b1, 1'b1);
        tbl[1]  = mk(1'b1, 2'd1, 2'b10, 4'b1111, 1'b1, 1'b1);
        tbl[2]  = mk(1'b1, 2'd2, 2'b11, 4'b1111, 1'b1, 1'b1);
        tbl[3]  = mk(1'b1, 2'd3, 2'b00, 4'b1111, 1'b1, 1'b1);
        tbl[4]  = mk(1'b0, 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0);
        // fill and stall lane 2, then release it
        tbl[5]  = mk(1'b1, 2'd2, 2'd1,  4'b1011, 1'b1, 1'b1);
        tbl[6]  = mk(1'b1, 2'd2, 2'd2,  4'b1011, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 2'd2, 2'd3,  4'b1011, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 2'd2, 2'd3,  4'b1111, 1'b1, 1'b0);  // pop at occ 2: no same-cycle refill
        tbl[9]  = mk(1'b1, 2'd2, 2'd3,  4'b1111, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 2'd0, 2'd0,  4'b1111, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 2'd0, 2'd0,  4'b1111, 1'b0, 1'b0);

        live  = 1'b0;
        rst_n = 1'b0;
        drv(1'b0, 2'd0, '0, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_valid", 32'(m_valid), 32'h0);
        chk("reset m_data", {24'h0, m_data3, m_data2, m_data1, m_data0}, 32'h0);
        rst_n = 1'b1;
        repeat (3) cyc();
        live = 1'b1;

        // table-driven vectors
        for (int k = 0; k < 12; k++) begin
            drv(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].mr);
            #1;
            if (tbl[k].chk) chk($sformatf("tbl[%0d] s_ready", k), 32'(s_ready), 32'(tbl[k].rdy));
            cyc();
        end

        // head-of-line blocking: lane 1 full, then retarget the stalled beat to lane 0
        drv(1'b1, 2'd1, 2'b01, 4'b1101); cyc();
        drv(1'b1, 2'd1, 2'b10, 4'b1101); cyc();
        drv(1'b1, 2'd1, 2'b11, 4'b1101);
        #1 chk("hol stalled s_ready", 32'(s_ready), 32'h0);
        cyc();
        drv(1'b1, 2'd0, 2'b11, 4'b1101);
        #1 chk("hol switched s_ready", 32'(s_ready), 32'h1);
        cyc();
        drv(1'b0, 2'd0, 2'b00, 4'b1111);
        repeat (3) cyc();

        // push and pop in the same cycle at occ 1
        drv(1'b1, 2'd3, 2'b01, 4'b1111); cyc();
        drv(1'b1, 2'd3, 2'b10, 4'b1111); cyc();
        drv(1'b0, 2'd0, 2'b00, 4'b1111);
        #1;
        chk("pushpop m_data3", 32'(m_data3), 32'h2);
        chk("pushpop m_valid", 32'(m_valid), 32'h8);
        repeat (2) cyc();

        // async reset with every lane full
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 2; j++) begin
                drv(1'b1, 2'(l), 2'(l + j + 1), 4'b0000);
                cyc();
            end
        end
        drv(1'b0, 2'd0, 2'b00, 4'b0000);
        #1 chk("full before reset", 32'(m_valid), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("async m_valid", 32'(m_valid), 32'h0);
        chk("async m_data", {24'h0, m_data3, m_data2, m_data1, m_data0}, 32'h0);
        for (int i = 0; i < 4; i++) sb[i].delete();
        live = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 4'b1111;
        repeat (4) cyc();   // model is empty: old beats must not come back
        live = 1'b1;
        drv(1'b1, 2'd1, 2'b10, 4'b1111); cyc();
        drv(1'b0, 2'd0, 2'b00, 4'b1111); repeat (2) cyc();

`ifdef DEMUX_CNT_EN
        // counters: everything delivered so far was cleared by the reset, except the lane-1 beat above
        for (int k = 0; k < 257; k++) begin
            drv(1'b1, 2'd0, k[1:0], 4'b1111);
            cyc();
        end
        drv(1'b0, 2'd0, 2'b00, 4'b1111);
        repeat (2) cyc();
        chk("m_cnt", m_cnt, 32'h0000_0101);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Inverse of the team's 4:1 lane selector: one 2-bit-wide input stream is routed to one of four output lanes, chosen by a per-beat select.
- Valid/ready handshake on the input and on every output.
- Each output lane has a 2-entry buffer, so a stalled lane does not block beats bound for other lanes, except for head-of-line blocking at the input.
- Sits downstream of a single producer; fans out to four independent consumers.

Parameters:
- W, 2, data width per beat (matches the team's lane width).
- DEPTH, 2, entries per output lane buffer. Fixed at 2; any other value is a synthesis-time error.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input beat present.
- s_ready  output  1  input beat accepted this cycle when s_valid & s_ready.
- s_sel  input  2  destination lane; 2'b00 selects lane 0 … 2'b11 selects lane 3. Sampled with the beat.
- s_data  input  W  input beat payload.
- m_valid  output  4  bit i: lane i head entry valid.
- m_ready  input  4  bit i: lane i consumer accepts.
- m_data0 .. m_data3  output  W each  lane head payload.
- (DEMUX_CNT_EN only) m_cnt  output  32  {cnt3,cnt2,cnt1,cnt0}, 8 bits each.

Behaviour:
- Reset (async assert, sync release to clk):
  - all lane occupancies = 0, m_valid = 4'b0000, m_data0..3 = 0, buffer contents = 0.
  - s_ready = 1 after reset if s_valid is present (see the s_ready rule).
- Per lane i:
  - occ_i ∈ {0, 1, 2}; 2-entry FIFO with head/tail pointers or equivalent shift.
  - push_i = s_valid & s_ready & (s_sel == i).
  - pop_i = m_valid[i] & m_ready[i].
- s_ready is combinational: s_ready = (occ[s_sel] != 2).
  - It depends on s_sel only, never on m_ready. There is no combinational path from m_ready to s_ready.
- m_valid[i] = (occ_i != 0). m_data_i is driven from the head register only, so m_* outputs are fully registered.
- Latency:
  - A beat accepted at edge N is visible on m_valid / m_data of its lane after edge N (one cycle).
  - Throughput is 1 beat/cycle per lane when the consumer holds m_ready high.
- Occupancy transitions:
  - occ 0 → 1 on push.
  - occ 1 → 2 on push without pop.
  - occ 1 → 1 on push with pop; head takes the new beat.
  - occ 2 → 1 on pop; second entry moves to head.
  - occ 1 → 0 on pop without push.
- Full lane:
  - occ = 2 with pop in the same cycle: s_ready is still 0 for that lane, so there is no same-cycle refill.
  - A beat stalled at the input for a full lane holds s_ready low even if other lanes are empty.
- Ordering: beats for the same lane are delivered in acceptance order. There is no ordering between lanes.
- The producer must hold s_data and s_sel stable while s_valid & ~s_ready. Changing s_sel while stalled is permitted, and s_ready re-evaluates for the new lane.
- Data registers load only on push. When a lane empties, m_data holds its last value (don't-care while m_valid = 0).
- Reset mid-operation: all buffered beats are discarded immediately and m_valid drops asynchronously to 0.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Four 8-bit counters, cnt_i incremented on each pop_i. Wrap 8'hFF → 8'h00.
  - Cleared on reset.
  - Exported on m_cnt.
- Not defined:
  - No counters, no m_cnt port.
  - Handshake behaviour identical in both builds.

Test Plan:
- Basic route:
  - Stimulus: m_ready = 4'b1111; send (sel, data) = (0,2'b01), (1,2'b10), (2,2'b11), (3,2'b00) on consecutive cycles.
  - Response: each lane shows m_valid for exactly one cycle, one cycle after acceptance, with the matching data. s_ready stays 1 throughout.
- Fill and stall:
  - Stimulus: m_ready[2] = 0; send three beats to lane 2 (data 1, 2, 3).
  - Response: first two accepted, occ_2 = 2, s_ready = 0 on the third.
  - Then raise m_ready[2]: third beat accepted the cycle after the first pop; output order is 1, 2, 3.
- Head-of-line blocking:
  - Stimulus: lane 1 full; present a beat for lane 1, then switch s_sel to 0 while stalled.
  - Response: s_ready goes 0 → 1; beat delivered on lane 0.
- Push/pop at occ 1:
  - Stimulus: lane 3 holds 2'b01 with m_ready[3] = 1; push 2'b10 in the same cycle.
  - Response: next cycle m_data3 = 2'b10, occ_3 = 1, m_valid[3] = 1.
- Async reset:
  - Stimulus: all lanes at occ = 2; assert rst_n low mid-cycle.
  - Response: m_valid = 0 immediately, without waiting for a clock edge. After release, old data never reappears.
- DEMUX_CNT_EN:
  - Stimulus: deliver 257 beats to lane 0.
  - Response: cnt0 = 8'h01; other counters = 0.
